// File: rtl/fround_pack.sv
// fround_pack: rounding/packing stage that sits directly behind fadd_sub.
// Takes an unrounded sign/exponent/fraction plus guard/round/sticky bits, applies the selected
// IEEE-754 rounding mode and emits a packed word with inexact/overflow flags.
// The stage uses the same level en/ready handshake as fadd_sub: en is held until ready is seen.
//
// Ports
//   fpu_clk            clock, rising edge
//   fpu_rst_n          synchronous active-low reset
//   fround_en_i        request level; inputs are captured only when the stage is idle
//   fround_rm_i        rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   fround_sign_i      sign
//   fround_exp_i       biased exponent
//   fround_frac_i      stored fraction (no hidden bit)
//   fround_grs_i       {guard, round, sticky}
//   fround_result_o    packed {sign, exp, frac}
//   fround_inexact_o   result differs from exact value
//   fround_overflow_o  rounding carried the exponent to all-ones
//   fround_ready_o     result/flags valid; held while fround_en_i stays high
module fround_pack #(
  parameter int unsigned OPERAND_WIDTH  = 32,
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned FRACTION_WIDTH = 23
) (
  input  logic                      fpu_clk,
  input  logic                      fpu_rst_n,
  input  logic                      fround_en_i,
  input  logic [2:0]                fround_rm_i,
  input  logic                      fround_sign_i,
  input  logic [EXPONENT_WIDTH-1:0] fround_exp_i,
  input  logic [FRACTION_WIDTH-1:0] fround_frac_i,
  input  logic [2:0]                fround_grs_i,
  output logic [OPERAND_WIDTH-1:0]  fround_result_o,
  output logic                      fround_inexact_o,
  output logic                      fround_overflow_o,
  output logic                      fround_ready_o
);

  localparam int unsigned EW = EXPONENT_WIDTH;
  localparam int unsigned FW = FRACTION_WIDTH;
  localparam int unsigned OW = OPERAND_WIDTH;

  localparam logic [EW-1:0] ExpOnes = '1;
  localparam logic [EW-1:0] ExpOne  = {{(EW-1){1'b0}}, 1'b1};

  localparam logic [2:0] RmRtz = 3'b001;
  localparam logic [2:0] RmRdn = 3'b010;
  localparam logic [2:0] RmRup = 3'b011;
  localparam logic [2:0] RmRmm = 3'b100;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StNorm  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    rm_q, rm_d;
  logic          sign_q, sign_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [FW-1:0] frac_q, frac_d;
  logic [2:0]    grs_q, grs_d;
  logic          inx_q, inx_d;
  logic [FW:0]   sum_q, sum_d;
  logic [OW-1:0] result_q, result_d;
  logic          inexact_q, inexact_d;
  logic          overflow_q, overflow_d;
  logic          ready_q, ready_d;

  logic          special;
  logic          inexact_calc;
  logic          inc;
  logic [EW-1:0] exp_r;
  logic [FW-1:0] frac_r;
  logic          ovf;

  always_comb begin
    state_d      = state_q;
    rm_d         = rm_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    frac_d       = frac_q;
    grs_d        = grs_q;
    inx_d        = inx_q;
    sum_d        = sum_q;
    result_d     = result_q;
    inexact_d    = inexact_q;
    overflow_d   = overflow_q;
    ready_d      = ready_q;
    // Inf/NaN operands pass through untouched.
    special      = (exp_q == ExpOnes);
    inexact_calc = 1'b0;
    inc          = 1'b0;
    exp_r        = exp_q;
    frac_r       = frac_q;
    ovf          = 1'b0;

    case (state_q)
      StIdle: begin
        result_d   = '0;
        inexact_d  = 1'b0;
        overflow_d = 1'b0;
        ready_d    = 1'b0;
        if (fround_en_i) begin
          rm_d    = fround_rm_i;
          sign_d  = fround_sign_i;
          exp_d   = fround_exp_i;
          frac_d  = fround_frac_i;
          grs_d   = fround_grs_i;
          state_d = StRound;
        end
      end

      StRound: begin
        if (!fround_en_i) begin
          state_d = StIdle;
        end else begin
          inexact_calc = ~special & (|grs_q);
          case (rm_q)
            RmRtz:   inc = 1'b0;
            RmRdn:   inc = sign_q & inexact_calc;
            RmRup:   inc = ~sign_q & inexact_calc;
            RmRmm:   inc = grs_q[2];
            default: inc = grs_q[2] & (grs_q[1] | grs_q[0] | frac_q[0]);
          endcase
          if (special) inc = 1'b0;
          inx_d   = inexact_calc;
          sum_d   = {1'b0, frac_q} + {{FW{1'b0}}, inc};
          state_d = StNorm;
        end
      end

      StNorm: begin
        if (!fround_en_i) begin
          state_d = StIdle;
        end else begin
          if (special) begin
            exp_r  = exp_q;
            frac_r = frac_q;
          end else if (sum_q[FW]) begin
            // Fraction carry-out bumps the exponent; this also lifts a subnormal to exp 1.
            exp_r  = exp_q + ExpOne;
            frac_r = '0;
          end else begin
            exp_r  = exp_q;
            frac_r = sum_q[FW-1:0];
          end
          ovf = ~special & (exp_r == ExpOnes);
          if (ovf) frac_r = '0;
          result_d   = OW'({sign_q, exp_r, frac_r});
          inexact_d  = inx_q;
          overflow_d = ovf;
          ready_d    = 1'b1;
          state_d    = StDone;
        end
      end

      default: begin
        if (!fround_en_i) begin
          result_d   = '0;
          inexact_d  = 1'b0;
          overflow_d = 1'b0;
          ready_d    = 1'b0;
          state_d    = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge fpu_clk) begin
    if (!fpu_rst_n) begin
      state_q    <= StIdle;
      rm_q       <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      frac_q     <= '0;
      grs_q      <= '0;
      inx_q      <= 1'b0;
      sum_q      <= '0;
      result_q   <= '0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rm_q       <= rm_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      frac_q     <= frac_d;
      grs_q      <= grs_d;
      inx_q      <= inx_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      inexact_q  <= inexact_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
    end
  end

  assign fround_result_o   = result_q;
  assign fround_inexact_o  = inexact_q;
  assign fround_overflow_o = overflow_q;
  assign fround_ready_o    = ready_q;

endmodule

// File: tb/tb_fround_pack.sv
module tb_fround_pack;

  logic        fpu_clk = 1'b0;
  logic        fpu_rst_n;
  logic        fround_en_i;
  logic [2:0]  fround_rm_i;
  logic        fround_sign_i;
  logic [7:0]  fround_exp_i;
  logic [22:0] fround_frac_i;
  logic [2:0]  fround_grs_i;
  logic [31:0] fround_result_o;
  logic        fround_inexact_o;
  logic        fround_overflow_o;
  logic        fround_ready_o;

  fround_pack #(
    .OPERAND_WIDTH (32),
    .EXPONENT_WIDTH(8),
    .FRACTION_WIDTH(23)
  ) dut (
    .fpu_clk          (fpu_clk),
    .fpu_rst_n        (fpu_rst_n),
    .fround_en_i      (fround_en_i),
    .fround_rm_i      (fround_rm_i),
    .fround_sign_i    (fround_sign_i),
    .fround_exp_i     (fround_exp_i),
    .fround_frac_i    (fround_frac_i),
    .fround_grs_i     (fround_grs_i),
    .fround_result_o  (fround_result_o),
    .fround_inexact_o (fround_inexact_o),
    .fround_overflow_o(fround_overflow_o),
    .fround_ready_o   (fround_ready_o)
  );

  always #5 fpu_clk = ~fpu_clk;

  typedef struct {
    logic [2:0]  rm;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [2:0]  grs;
    logic [31:0] res;
    logic        inx;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic set_inputs(input vec_t v);
    fround_rm_i   = v.rm;
    fround_sign_i = v.s;
    fround_exp_i  = v.e;
    fround_frac_i = v.f;
    fround_grs_i  = v.grs;
  endtask

  // Drives one request, waits (bounded) for ready, then drops en for one edge.
  task automatic drive_op(input vec_t v, output logic [31:0] r, output logic inx,
                          output logic ovf, output int lat, output logic rdy_after);
    @(negedge fpu_clk);
    set_inputs(v);
    fround_en_i = 1'b1;
    lat = 0;
    do begin
      @(posedge fpu_clk);
      #1;
      lat++;
    end while (!fround_ready_o && lat < 8);
    r   = fround_result_o;
    inx = fround_inexact_o;
    ovf = fround_overflow_o;
    @(negedge fpu_clk);
    fround_en_i = 1'b0;
    @(posedge fpu_clk);
    #1;
    rdy_after = fround_ready_o;
  endtask

  task automatic run_table(input string name, input vec_t tbl[]);
    logic [31:0] r;
    logic        inx, ovf, rdy_after;
    int          lat;
    exp_t        e;
    foreach (tbl[i]) begin
      sb.push_back('{res: tbl[i].res, inx: tbl[i].inx, ovf: tbl[i].ovf});
      drive_op(tbl[i], r, inx, ovf, lat, rdy_after);
      e = sb.pop_front();
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL %s[%0d] latency got %0d want 3", name, i, lat);
      end
      checks++;
      if (r !== e.res) begin
        errors++;
        $display("FAIL %s[%0d] result got %h want %h", name, i, r, e.res);
      end
      checks++;
      if (inx !== e.inx) begin
        errors++;
        $display("FAIL %s[%0d] inexact got %b want %b", name, i, inx, e.inx);
      end
      checks++;
      if (ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s[%0d] overflow got %b want %b", name, i, ovf, e.ovf);
      end
      checks++;
      if (rdy_after !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] ready after drop got %b want 0", name, i, rdy_after);
      end
    end
  endtask

  task automatic test_reset();
    fpu_rst_n   = 1'b0;
    fround_en_i = 1'b0;
    set_inputs('{rm: 3'b0, s: 1'b0, e: 8'h0, f: 23'h0, grs: 3'b0, res: 32'h0, inx: 1'b0,
                 ovf: 1'b0});
    repeat (2) @(posedge fpu_clk);
    #1;
    checks++;
    if ({fround_result_o, fround_inexact_o, fround_overflow_o, fround_ready_o} !== 35'h0) begin
      errors++;
      $display("FAIL reset outputs got %h/%b/%b/%b want 0", fround_result_o, fround_inexact_o,
               fround_overflow_o, fround_ready_o);
    end
    @(negedge fpu_clk);
    fpu_rst_n = 1'b1;
  endtask

  task automatic test_rounding();
    vec_t tbl[] = '{
      '{3'b000, 1'b0, 8'h80, 23'h000001, 3'b100, 32'h40000002, 1'b1, 1'b0},
      '{3'b000, 1'b0, 8'h80, 23'h000000, 3'b100, 32'h40000000, 1'b1, 1'b0},
      '{3'b100, 1'b0, 8'h80, 23'h000000, 3'b100, 32'h40000001, 1'b1, 1'b0},
      '{3'b000, 1'b0, 8'h80, 23'h000000, 3'b101, 32'h40000001, 1'b1, 1'b0},
      '{3'b000, 1'b0, 8'h80, 23'h000000, 3'b011, 32'h40000000, 1'b1, 1'b0},
      '{3'b111, 1'b0, 8'h80, 23'h000001, 3'b100, 32'h40000002, 1'b1, 1'b0},
      '{3'b011, 1'b1, 8'h80, 23'h000005, 3'b001, 32'hC0000005, 1'b1, 1'b0},
      '{3'b010, 1'b1, 8'h80, 23'h000005, 3'b001, 32'hC0000006, 1'b1, 1'b0},
      '{3'b100, 1'b0, 8'h80, 23'h123456, 3'b000, 32'h40123456, 1'b0, 1'b0}
    };
    run_table("round", tbl);
  endtask

  task automatic test_carry_overflow();
    vec_t tbl[] = '{
      '{3'b000, 1'b0, 8'h80, 23'h7FFFFF, 3'b110, 32'h40800000, 1'b1, 1'b0},
      '{3'b011, 1'b0, 8'hFE, 23'h7FFFFF, 3'b111, 32'h7F800000, 1'b1, 1'b1},
      '{3'b001, 1'b0, 8'hFE, 23'h7FFFFF, 3'b111, 32'h7F7FFFFF, 1'b1, 1'b0},
      '{3'b010, 1'b1, 8'hFE, 23'h7FFFFF, 3'b111, 32'hFF800000, 1'b1, 1'b1},
      '{3'b011, 1'b1, 8'hFE, 23'h7FFFFF, 3'b111, 32'hFF7FFFFF, 1'b1, 1'b0}
    };
    run_table("carry", tbl);
  endtask

  task automatic test_special();
    vec_t tbl[] = '{
      '{3'b000, 1'b0, 8'h00, 23'h7FFFFF, 3'b100, 32'h00800000, 1'b1, 1'b0},
      '{3'b000, 1'b0, 8'hFF, 23'h400000, 3'b111, 32'h7FC00000, 1'b0, 1'b0},
      '{3'b011, 1'b0, 8'hFF, 23'h400000, 3'b111, 32'h7FC00000, 1'b0, 1'b0},
      '{3'b100, 1'b1, 8'hFF, 23'h000000, 3'b111, 32'hFF800000, 1'b0, 1'b0},
      '{3'b010, 1'b1, 8'h12, 23'h0ABCDE, 3'b000, 32'h890ABCDE, 1'b0, 1'b0}
    };
    run_table("special", tbl);
  endtask

  task automatic test_handshake();
    vec_t v = '{3'b000, 1'b0, 8'h80, 23'h000001, 3'b100, 32'h40000002, 1'b1, 1'b0};
    exp_t e;
    int   lat;
    sb.push_back('{res: v.res, inx: v.inx, ovf: v.ovf});
    @(negedge fpu_clk);
    set_inputs(v);
    fround_en_i = 1'b1;
    @(posedge fpu_clk);
    #1;
    lat = 1;
    // Stage is now past capture; scribble over every input.
    set_inputs('{3'b011, 1'b1, 8'hFE, 23'h7FFFFF, 3'b111, 32'h0, 1'b0, 1'b0});
    while (!fround_ready_o && lat < 8) begin
      @(posedge fpu_clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL hs latency got %0d want 3", lat);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (fround_ready_o !== 1'b1 || fround_result_o !== e.res || fround_inexact_o !== e.inx
          || fround_overflow_o !== e.ovf) begin
        errors++;
        $display("FAIL hs hold[%0d] got %b/%h/%b/%b want 1/%h/%b/%b", c, fround_ready_o,
                 fround_result_o, fround_inexact_o, fround_overflow_o, e.res, e.inx, e.ovf);
      end
      @(posedge fpu_clk);
      #1;
    end
    @(negedge fpu_clk);
    fround_en_i = 1'b0;
    @(posedge fpu_clk);
    #1;
    checks++;
    if (fround_ready_o !== 1'b0 || fround_result_o !== 32'h0 || fround_inexact_o !== 1'b0) begin
      errors++;
      $display("FAIL hs drop got %b/%h/%b want 0/0/0", fround_ready_o, fround_result_o,
               fround_inexact_o);
    end
  endtask

  task automatic test_abort_reset();
    vec_t v = '{3'b011, 1'b0, 8'hFE, 23'h7FFFFF, 3'b111, 32'h7F800000, 1'b1, 1'b1};
    logic seen;
    // Abort in NORM (drop after 2 edges) and in ROUND (drop after 1 edge).
    for (int k = 2; k >= 1; k--) begin
      @(negedge fpu_clk);
      set_inputs(v);
      fround_en_i = 1'b1;
      repeat (k) @(negedge fpu_clk);
      fround_en_i = 1'b0;
      seen = 1'b0;
      repeat (5) begin
        @(posedge fpu_clk);
        #1;
        if (fround_ready_o || fround_result_o != 0 || fround_overflow_o) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL abort%0d outputs got active want quiet", k);
      end
    end
    run_table("after_abort", '{v});
    // Reset while parked in DONE with en still high.
    @(negedge fpu_clk);
    set_inputs(v);
    fround_en_i = 1'b1;
    repeat (3) @(posedge fpu_clk);
    #1;
    checks++;
    if (fround_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_done precondition ready got %b want 1", fround_ready_o);
    end
    @(negedge fpu_clk);
    fpu_rst_n = 1'b0;
    @(posedge fpu_clk);
    #1;
    checks++;
    if ({fround_result_o, fround_inexact_o, fround_overflow_o, fround_ready_o} !== 35'h0) begin
      errors++;
      $display("FAIL rst_done outputs got %h/%b/%b/%b want 0", fround_result_o,
               fround_inexact_o, fround_overflow_o, fround_ready_o);
    end
    @(negedge fpu_clk);
    fpu_rst_n   = 1'b1;
    fround_en_i = 1'b0;
    run_table("after_reset",
              '{'{3'b001, 1'b0, 8'hFE, 23'h7FFFFF, 3'b111, 32'h7F7FFFFF, 1'b1, 1'b0}});
  endtask

  task automatic test_back_to_back();
    vec_t tbl[] = '{
      '{3'b000, 1'b1, 8'h01, 23'h000002, 3'b110, 32'h80800003, 1'b1, 1'b0},
      '{3'b010, 1'b0, 8'h7F, 23'h3FFFFF, 3'b010, 32'h3FBFFFFF, 1'b1, 1'b0},
      '{3'b011, 1'b0, 8'h7F, 23'h3FFFFF, 3'b010, 32'h3FC00000, 1'b1, 1'b0},
      '{3'b100, 1'b1, 8'h20, 23'h7FFFFE, 3'b011, 32'h907FFFFE, 1'b1, 1'b0}
    };
    run_table("b2b", tbl);
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_carry_overflow();
    test_special();
    test_handshake();
    test_abort_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
